fxp_alu_seq: RTL and testbench
==============================

# fxp_alu_seq

Parametrised sequential sign-magnitude fixed-point ALU with valid/ready handshakes. It is the next-generation arithmetic core behind the FPU front end. Operands arrive as sign + INT_W integer bits + FRAC_W fraction bits, and the block computes add, subtract, multiply or divide without an IEEE-754 round trip. Results go out on a held valid/ready interface with overflow and divide-by-zero flags.

## Interface
- INT_W, 8, integer-part width (≥1)
- FRAC_W, 8, fraction-part width (≥1); W = INT_W+FRAC_W is the magnitude width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  high only in IDLE
- sign_a, sign_b  in  1  operand signs (1 = negative)
- int_a, int_b  in  INT_W  integer magnitudes
- frac_a, frac_b  in  FRAC_W  fraction magnitudes
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts
- out_sign  out  1  result sign
- out_int  out  INT_W  result integer magnitude
- out_frac  out  FRAC_W  result fraction magnitude
- overflow  out  1  magnitude exceeded W bits
- div_zero  out  1  divisor magnitude was 0
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ADDSUB, MUL, DIV, PACK, DONE.
- IDLE: on in_valid&in_ready, register ma={int_a,frac_a}, mb={int_b,frac_b}, signs and op.
  - For op=01, sign_b is inverted on capture.
  - op 00/01 → ADDSUB; 10 → MUL; 11 with mb≠0 → DIV; 11 with mb=0 → PACK with div_zero and overflow set.
- ADDSUB (1 cycle):
  - Equal signs: mag = ma+mb (W+1 bits), sign = sa.
  - Unequal signs: mag = larger−smaller, sign of the larger.
  - Carry out of W bits sets overflow.
- MUL: shift-add, one multiplier bit per cycle, W cycles, 2W-bit product P.
  - mag = P[W+FRAC_W-1:FRAC_W] (truncate).
  - overflow = |P[2W-1:W+FRAC_W].
- DIV: restoring division of (ma<<FRAC_W) by mb, one quotient bit per cycle, W+FRAC_W cycles.
  - mag = low W quotient bits, truncated.
  - overflow if any higher quotient bit is set.
- Sign for MUL and DIV: sa^sb.
- PACK:
  - Apply the overflow policy (see Configuration). Divide-by-zero always gives mag all-ones.
  - If the final mag is 0, force out_sign=0 (no −0).
  - Register the outputs, then go to DONE.
- DONE: out_valid=1 and all outputs stable. On out_ready go to IDLE, clearing out_valid on that edge. There is no same-cycle re-accept.
- Flags are registered with the result and keep their value until the next PACK.
- Inputs are ignored outside the IDLE accept edge. Changing op or operands mid-operation has no effect.

## Timing
- Reset (reset_n low, asynchronous, any state including mid-MUL/DIV):
  - state=IDLE, all datapath registers and counters cleared.
  - out_valid=0, out_sign=0, out_int=0, out_frac=0, overflow=0, div_zero=0, busy=0.
  - in_ready=1 on the first cycle after reset deasserts.
- Latency, counted in edges from the accept edge to the first cycle out_valid=1:
  - add/sub: 2.
  - mul: W+1.
  - div: W+FRAC_W+1.
  - div by zero: 1.
- in_ready is combinational from the state (state==IDLE). It never depends on in_valid.
- Backpressure: out_valid stays high for an unbounded time with outputs unchanged while out_ready=0.
- Iteration counter is ceil(log2(W+FRAC_W+1)) bits and resets to 0 on entry to MUL/DIV.

## Configuration
- FXP_ALU_SAT_EN:
  - Defined: on overflow the magnitude saturates to all-ones (max representable), sign kept.
  - Undefined: on overflow the magnitude wraps to the low W bits of the exact result; overflow flag still set.
  - Divide-by-zero always outputs all-ones magnitude regardless of the macro.

## Test plan
Default parameters (INT_W=8, FRAC_W=8) and FXP_ALU_SAT_EN defined unless noted.
- Add: +3.5 + (−1.25) (int 3/frac 0x80, sign_b=1 int 1/frac 0x40) → +2.25 (int 2, frac 0x40), flags 0, out_valid 2 edges after accept.
- Sub: 1.5 − 1.5 → int 0, frac 0, out_sign=0.
- Mul: −2.5 × 1.5 → sign 1, int 3, frac 0xC0, out_valid 17 edges after accept.
- Div: 1.0 ÷ 3.0 → int 0, frac 0x55, out_valid 25 edges after accept. Then 5.0 ÷ 0 → div_zero=1, overflow=1, int 0xFF, frac 0xFF, latency 1.
- Overflow: 200 × 2 → overflow=1. Saturated result int 0xFF, frac 0xFF. With the macro undefined: int 0x90, frac 0x00.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout; accept, and in_ready=1 the next cycle.
  - Pull reset_n low mid-MUL → all outputs 0 immediately; after release, a new add completes correctly.

Source files
------------

// File: rtl/fxp_alu_seq_if.sv
// fxp_alu_seq_if: operand/result handshake bundle for the sequential
// sign-magnitude fixed-point ALU. The master drives operands and out_ready;
// the slave (the ALU) drives in_ready, results and status flags.
interface fxp_alu_seq_if #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              sign_a;
    logic              sign_b;
    logic [INT_W-1:0]  int_a;
    logic [INT_W-1:0]  int_b;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;
    logic [1:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [INT_W-1:0]  out_int;
    logic [FRAC_W-1:0] out_frac;
    logic              overflow;
    logic              div_zero;
    logic              busy;

    modport master (
        output in_valid, sign_a, sign_b, int_a, int_b, frac_a, frac_b, op,
               out_ready,
        input  in_ready, out_valid, out_sign, out_int, out_frac, overflow,
               div_zero, busy
    );

    modport slave (
        input  in_valid, sign_a, sign_b, int_a, int_b, frac_a, frac_b, op,
               out_ready,
        output in_ready, out_valid, out_sign, out_int, out_frac, overflow,
               div_zero, busy
    );
endinterface

// File: rtl/fxp_alu_seq.sv
// fxp_alu_seq: sequential sign-magnitude fixed-point ALU (add/sub/mul/div).
// Multiply is shift-add (one bit per cycle), divide is restoring (one
// quotient bit per cycle). Results are held on a valid/ready interface.
// Build option: define FXP_ALU_SAT_EN to saturate the magnitude on overflow;
// otherwise the magnitude wraps to the low W bits of the exact result.
module fxp_alu_seq #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    fxp_alu_seq_if.slave bus
);
    localparam int W  = INT_W + FRAC_W;
    localparam int QW = W + FRAC_W;
    localparam int CW = $clog2(QW + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(QW - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDSUB = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_PACK   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [W-1:0]      ma_q, ma_d;
    logic [W-1:0]      mb_q, mb_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [1:0]        op_q, op_d;
    logic              dz_q, dz_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [W-1:0]      as_mag_q, as_mag_d;
    logic              as_ovf_q, as_ovf_d;
    logic              as_sign_q, as_sign_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic [W-1:0]      out_mag_q, out_mag_d;
    logic              ovf_q, ovf_d;
    logic              dzo_q, dzo_d;

    // Datapath helpers
    logic [W:0]        sum_ext;
    logic              a_ge_b;
    logic [W-1:0]      diff;
    logic [W:0]        mul_sum;
    logic [W:0]        div_sh;
    logic [W:0]        div_sub;
    logic              div_ge;
    logic [W-1:0]      raw_mag;
    logic              raw_ovf;
    logic              raw_sign;
    logic [W-1:0]      fin_mag;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_int   = out_mag_q[W-1:FRAC_W];
    assign bus.out_frac  = out_mag_q[FRAC_W-1:0];
    assign bus.overflow  = ovf_q;
    assign bus.div_zero  = dzo_q;

    // Arithmetic step values, result selection and overflow policy
    always_comb begin
        sum_ext = {1'b0, ma_q} + {1'b0, mb_q};
        a_ge_b  = (ma_q >= mb_q);
        diff    = a_ge_b ? (ma_q - mb_q) : (mb_q - ma_q);

        // Shift-add: high half accumulates, low half holds remaining multiplier bits
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, ma_q} : '0);

        // Restoring divide: dividend bits stream out of quo_q MSB-first while
        // quotient bits shift in at the LSB
        div_sh  = {rem_q, quo_q[QW-1]};
        div_sub = div_sh - {1'b0, mb_q};
        div_ge  = (div_sh >= {1'b0, mb_q});

        raw_mag  = as_mag_q;
        raw_ovf  = as_ovf_q;
        raw_sign = as_sign_q;
        if (op_q == OP_MUL) begin
            raw_mag  = acc_q[W+FRAC_W-1:FRAC_W];
            raw_ovf  = |acc_q[2*W-1:W+FRAC_W];
            raw_sign = sa_q ^ sb_q;
        end else if (op_q == OP_DIV) begin
            raw_sign = sa_q ^ sb_q;
            if (dz_q) begin
                raw_mag = '1;
                raw_ovf = 1'b1;
            end else begin
                raw_mag = quo_q[W-1:0];
                raw_ovf = |quo_q[QW-1:W];
            end
        end

        fin_mag = raw_mag;
        if (dz_q) begin
            fin_mag = '1;
        end
`ifdef FXP_ALU_SAT_EN
        else if (raw_ovf) begin
            fin_mag = '1;
        end
`else
        else begin
            fin_mag = raw_mag;
        end
`endif
    end

    // Next-state and register update logic for the controller
    always_comb begin
        state_d     = state_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        op_d        = op_q;
        dz_d        = dz_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        as_mag_d    = as_mag_q;
        as_ovf_d    = as_ovf_q;
        as_sign_d   = as_sign_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_mag_d   = out_mag_q;
        ovf_d       = ovf_q;
        dzo_d       = dzo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    ma_d  = {bus.int_a, bus.frac_a};
                    mb_d  = {bus.int_b, bus.frac_b};
                    sa_d  = bus.sign_a;
                    sb_d  = bus.sign_b ^ (bus.op == OP_SUB);
                    op_d  = bus.op;
                    dz_d  = (bus.op == OP_DIV) && ({bus.int_b, bus.frac_b} == '0);
                    cnt_d = '0;
                    acc_d = {{W{1'b0}}, bus.int_b, bus.frac_b};
                    rem_d = '0;
                    quo_d = {bus.int_a, bus.frac_a, {FRAC_W{1'b0}}};
                    case (bus.op)
                        OP_MUL:  state_d = S_MUL;
                        OP_DIV:  state_d = (dz_d) ? S_PACK : S_DIV;
                        default: state_d = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB: begin
                if (sa_q == sb_q) begin
                    as_mag_d  = sum_ext[W-1:0];
                    as_ovf_d  = sum_ext[W];
                    as_sign_d = sa_q;
                end else begin
                    as_mag_d  = diff;
                    as_ovf_d  = 1'b0;
                    as_sign_d = a_ge_b ? sa_q : sb_q;
                end
                state_d = S_PACK;
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MUL_LAST) begin
                    state_d = S_PACK;
                end
            end
            S_DIV: begin
                rem_d = div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
                quo_d = {quo_q[QW-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    state_d = S_PACK;
                end
            end
            S_PACK: begin
                out_mag_d   = fin_mag;
                out_sign_d  = (fin_mag == '0) ? 1'b0 : raw_sign;
                ovf_d       = raw_ovf;
                dzo_d       = dz_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ma_q        <= '0;
            mb_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            op_q        <= '0;
            dz_q        <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            as_mag_q    <= '0;
            as_ovf_q    <= 1'b0;
            as_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mag_q   <= '0;
            ovf_q       <= 1'b0;
            dzo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            op_q        <= op_d;
            dz_q        <= dz_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            as_mag_q    <= as_mag_d;
            as_ovf_q    <= as_ovf_d;
            as_sign_q   <= as_sign_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mag_q   <= out_mag_d;
            ovf_q       <= ovf_d;
            dzo_q       <= dzo_d;
        end
    end
endmodule

// File: tb/tb_fxp_alu_seq.sv
// tb_fxp_alu_seq: directed vectors for fxp_alu_seq at INT_W=8, FRAC_W=8.
// Overflow expectations follow FXP_ALU_SAT_EN (saturate vs. wrap).
module tb_fxp_alu_seq;
    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   lat;

    fxp_alu_seq_if #(.INT_W(8), .FRAC_W(8)) bus ();

    fxp_alu_seq #(.INT_W(8), .FRAC_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, wait for the accept edge, then scramble inputs
    // and count edges until out_valid rises (bounded).
    task automatic run_op(input string tag, input logic sa, input logic [7:0] ia, input logic [7:0] fa,
                          input logic sb, input logic [7:0] ib, input logic [7:0] fb,
                          input logic [1:0] op, output int latency);
        check({tag, ".in_ready_pre"}, bus.in_ready, 1'b1);
        bus.sign_a = sa; bus.int_a = ia; bus.frac_a = fa;
        bus.sign_b = sb; bus.int_b = ib; bus.frac_b = fb;
        bus.op = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.int_a = 8'hA5; bus.frac_a = 8'h5A; bus.int_b = 8'h00; bus.frac_b = 8'h00;
        bus.sign_a = ~sa; bus.op = ~op;
        check({tag, ".busy"}, bus.busy, 1'b1);
        check({tag, ".in_ready_busy"}, bus.in_ready, 1'b0);
        latency = 0;
        do begin
            @(posedge clk); #1;
            latency++;
        end while (!bus.out_valid && latency < 100);
    endtask

    task automatic check_res(input string tag, input int latency, input int exp_lat,
                             input logic s, input logic [7:0] i, input logic [7:0] f,
                             input logic ov, input logic dz);
        check({tag, ".latency"}, latency, exp_lat);
        check({tag, ".sign"}, bus.out_sign, s);
        check({tag, ".int"}, bus.out_int, i);
        check({tag, ".frac"}, bus.out_frac, f);
        check({tag, ".overflow"}, bus.overflow, ov);
        check({tag, ".div_zero"}, bus.div_zero, dz);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".valid_clr"}, bus.out_valid, 1'b0);
        check({tag, ".in_ready_post"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 2'b00;
        bus.sign_a = 1'b0; bus.int_a = '0; bus.frac_a = '0;
        bus.sign_b = 1'b0; bus.int_b = '0; bus.frac_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.out_int", bus.out_int, 8'h00);
        check("rst.out_frac", bus.out_frac, 8'h00);
        check("rst.flags", {bus.overflow, bus.div_zero, bus.out_sign}, 3'b000);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", bus.in_ready, 1'b1);

        // +3.5 + (-1.25) = +2.25
        run_op("add", 1'b0, 8'd3, 8'h80, 1'b1, 8'd1, 8'h40, 2'b00, lat);
        check_res("add", lat, 2, 1'b0, 8'd2, 8'h40, 1'b0, 1'b0);
        take("add");

        // 1.5 - 1.5 = +0
        run_op("sub0", 1'b0, 8'd1, 8'h80, 1'b0, 8'd1, 8'h80, 2'b01, lat);
        check_res("sub0", lat, 2, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
        take("sub0");

        // -2.5 * 1.5 = -3.75
        run_op("mul", 1'b1, 8'd2, 8'h80, 1'b0, 8'd1, 8'h80, 2'b10, lat);
        check_res("mul", lat, 17, 1'b1, 8'd3, 8'hC0, 1'b0, 1'b0);
        take("mul");

        // 1.0 / 3.0 = 0x0055, then hold under backpressure
        run_op("div", 1'b0, 8'd1, 8'h00, 1'b0, 8'd3, 8'h00, 2'b11, lat);
        check_res("div", lat, 25, 1'b0, 8'd0, 8'h55, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp.out_valid", bus.out_valid, 1'b1);
            check("bp.in_ready", bus.in_ready, 1'b0);
            check("bp.result", {bus.out_sign, bus.out_int, bus.out_frac}, {1'b0, 8'h00, 8'h55});
        end
        take("div");

        // 200 * 2 = 400: overflow
        run_op("mulovf", 1'b0, 8'd200, 8'h00, 1'b0, 8'd2, 8'h00, 2'b10, lat);
`ifdef FXP_ALU_SAT_EN
        check_res("mulovf", lat, 17, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
`else
        check_res("mulovf", lat, 17, 1'b0, 8'h90, 8'h00, 1'b1, 1'b0);
`endif
        take("mulovf");

        // 200 + 100 = 300: carry out of W bits
        run_op("addovf", 1'b0, 8'd200, 8'h00, 1'b0, 8'd100, 8'h00, 2'b00, lat);
`ifdef FXP_ALU_SAT_EN
        check_res("addovf", lat, 2, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
`else
        check_res("addovf", lat, 2, 1'b0, 8'h2C, 8'h00, 1'b1, 1'b0);
`endif
        take("addovf");

        // -200 / 0.5 = -400: quotient exceeds W bits
        run_op("divovf", 1'b1, 8'd200, 8'h00, 1'b0, 8'd0, 8'h80, 2'b11, lat);
`ifdef FXP_ALU_SAT_EN
        check_res("divovf", lat, 25, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
`else
        check_res("divovf", lat, 25, 1'b1, 8'h90, 8'h00, 1'b1, 1'b0);
`endif
        take("divovf");

        // -1.0 * 0 = +0 (no negative zero)
        run_op("mulz", 1'b1, 8'd1, 8'h00, 1'b0, 8'd0, 8'h00, 2'b10, lat);
        check_res("mulz", lat, 17, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
        take("mulz");

        // 1.25 - 3.5 = -2.25
        run_op("subneg", 1'b0, 8'd1, 8'h40, 1'b0, 8'd3, 8'h80, 2'b01, lat);
        check_res("subneg", lat, 2, 1'b1, 8'd2, 8'h40, 1'b0, 1'b0);
        take("subneg");

        // 5.0 / 0: divide-by-zero, flags persist after acceptance
        run_op("divz", 1'b0, 8'd5, 8'h00, 1'b0, 8'd0, 8'h00, 2'b11, lat);
        check_res("divz", lat, 1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        take("divz");
        check("divz.flags_held", {bus.overflow, bus.div_zero}, 2'b11);

        // Reset asserted mid-multiply clears everything immediately
        bus.sign_a = 1'b0; bus.int_a = 8'd1; bus.frac_a = 8'h00;
        bus.sign_b = 1'b0; bus.int_b = 8'd1; bus.frac_b = 8'h00;
        bus.op = 2'b10; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.out_valid", bus.out_valid, 1'b0);
        check("midrst.busy", bus.busy, 1'b0);
        check("midrst.result", {bus.out_sign, bus.out_int, bus.out_frac}, 17'h0);
        check("midrst.flags", {bus.overflow, bus.div_zero}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst.in_ready", bus.in_ready, 1'b1);

        // Fresh add after reset: -0.75 + -0.5 = -1.25
        run_op("add2", 1'b1, 8'd0, 8'hC0, 1'b1, 8'd0, 8'h80, 2'b00, lat);
        check_res("add2", lat, 2, 1'b1, 8'd1, 8'h40, 1'b0, 1'b0);
        take("add2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
